// File: rtl/qeciphy_tg_pkg.sv
// Shared checker state type, sequence seed and sequence step function for the traffic generator/checker.
// Defining QECIPHY_TG_PRBS_EN swaps the counter sequence for a 64-bit Fibonacci LFSR.
package qeciphy_tg_pkg;

    // Widest word the sequence function handles; narrower words use its low bits.
    localparam int TG_MAX_W = 64;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

`ifdef QECIPHY_TG_PRBS_EN
    localparam logic [TG_MAX_W-1:0] SEED = 64'h1;
`else
    localparam logic [TG_MAX_W-1:0] SEED = 64'h0;
`endif

    function automatic logic [TG_MAX_W-1:0] next_word(input logic [TG_MAX_W-1:0] w);
`ifdef QECIPHY_TG_PRBS_EN
        // x^64 + x^63 + x^61 + x^60 + 1, shifted towards the MSB
        return {w[62:0], w[63] ^ w[62] ^ w[60] ^ w[59]};
`else
        return w + 64'd1;
`endif
    endfunction

endpackage

// File: rtl/qeciphy_tg_checker.sv
// RX sequence checker: SEEK/LOCKED tracking, reference word, saturating error count and RX beat count.
// The sequence itself (counter or QECIPHY_TG_PRBS_EN LFSR) comes from qeciphy_tg_pkg::next_word.
module qeciphy_tg_checker
    import qeciphy_tg_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     link_ready_i,
    input  logic                     clear_i,
    input  logic                     rx_valid_i,
    input  logic [DATA_WIDTH-1:0]    rx_data_i,
    output logic                     locked_o,
    output logic                     err_sticky_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic [31:0]              rx_count_o
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

    chk_state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]     ref_q, ref_d;
    logic [MATCH_W-1:0]        match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]         miss_cnt_q, miss_cnt_d;
    logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic                      err_sticky_q, err_sticky_d;
    logic [31:0]               rx_count_q, rx_count_d;
    logic                      hit;

    function automatic logic [DATA_WIDTH-1:0] seq_next(input logic [DATA_WIDTH-1:0] w);
        return DATA_WIDTH'(next_word(TG_MAX_W'(w)));
    endfunction

    assign hit = (rx_data_i == ref_q);

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        rx_count_d   = rx_count_q;

        if (rx_valid_i) begin
            rx_count_d = rx_count_q + 32'd1;
            unique case (state_q)
                SEEK: begin
                    // A miss restarts the run at 1: the beat itself seeds the next reference.
                    match_cnt_d = hit ? match_cnt_q + MATCH_W'(1) : MATCH_W'(1);
                    ref_d       = seq_next(rx_data_i);
                    if (match_cnt_d >= MATCH_W'(LOCK_COUNT)) begin
                        state_d    = LOCKED;
                        miss_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        ref_d      = seq_next(ref_q);
                        miss_cnt_d = '0;
                    end else begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
                        end
                        err_sticky_d = 1'b1;
                        ref_d        = seq_next(rx_data_i);
                        miss_cnt_d   = miss_cnt_q + MISS_W'(1);
                        if (miss_cnt_d >= MISS_W'(UNLOCK_COUNT)) begin
                            state_d     = SEEK;
                            match_cnt_d = '0;
                        end
                    end
                end
                default: state_d = SEEK;
            endcase
        end

        // Lock is never held (or gained) while the link is down.
        if (!link_ready_i && state_d == LOCKED) begin
            state_d     = SEEK;
            match_cnt_d = '0;
        end

        if (clear_i) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
            rx_count_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= SEEK;
            ref_q        <= DATA_WIDTH'(SEED);
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
            rx_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
            rx_count_q   <= rx_count_d;
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign err_sticky_o = err_sticky_q;
    assign err_count_o  = err_count_q;
    assign rx_count_o   = rx_count_q;

endmodule

// File: rtl/qeciphy_traffic_gen_chk.sv
// AXI-Stream traffic generator plus RX checker wrapped around QECIPHY for hardware example designs.
// Sequence is a counter by default, or the 64-bit LFSR when QECIPHY_TG_PRBS_EN is defined.
module qeciphy_traffic_gen_chk
    import qeciphy_tg_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic                     ACLK,
    input  logic                     ARSTn,
    input  logic                     gen_enable,
    input  logic                     link_ready,
    input  logic                     clear,
    output logic [DATA_WIDTH-1:0]    TX_TDATA,
    output logic                     TX_TVALID,
    input  logic                     TX_TREADY,
    input  logic [DATA_WIDTH-1:0]    RX_TDATA,
    input  logic                     RX_TVALID,
    output logic                     RX_TREADY,
    output logic                     locked,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [31:0]              tx_count,
    output logic [31:0]              rx_count
);

    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [31:0]           tx_count_q, tx_count_d;
    logic                  tx_hs;

    assign tx_hs = tx_valid_q & TX_TREADY;

    always_comb begin
        // A pending beat stays up until accepted regardless of enable/link.
        tx_valid_d = (tx_valid_q & ~TX_TREADY) | (gen_enable & link_ready);
        tx_data_d  = tx_data_q;
        tx_count_d = tx_count_q;
        if (tx_hs) begin
            tx_data_d  = DATA_WIDTH'(next_word(TG_MAX_W'(tx_data_q)));
            tx_count_d = tx_count_q + 32'd1;
        end
        if (clear) begin
            tx_count_d = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= DATA_WIDTH'(SEED);
            tx_count_q <= '0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign TX_TVALID = tx_valid_q;
    assign TX_TDATA  = tx_data_q;
    assign tx_count  = tx_count_q;
    assign RX_TREADY = 1'b1;

    qeciphy_tg_checker #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_COUNT  (UNLOCK_COUNT)
    ) u_checker (
        .clk_i        (ACLK),
        .rst_ni       (ARSTn),
        .link_ready_i (link_ready),
        .clear_i      (clear),
        .rx_valid_i   (RX_TVALID),
        .rx_data_i    (RX_TDATA),
        .locked_o     (locked),
        .err_sticky_o (err_sticky),
        .err_count_o  (err_count),
        .rx_count_o   (rx_count)
    );

endmodule
